// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the pipelined MIPS datapath.
// Owns the PC, drives the instruction-memory request/ready handshake and
// writes the IF/ID pipeline register. A one-entry hold buffer keeps an
// instruction that arrives while decode is stalled; a DROP state swallows
// the reply of a request that was outstanding when a redirect arrived.
// Optional feature macro: IF_STALL_COUNT_EN adds a saturating stall counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
`ifdef IF_STALL_COUNT_EN
    output logic [31:0] stall_count,
`endif
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        if_flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] redirect_pc, redirect_pc_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] hold_pc4, hold_pc4_n;
    logic [31:0] id_instr_n, id_pc4_n;
    logic        id_valid_n;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        advance;

    assign pc_plus4 = pc + 32'd4;
    assign target   = branch_target & 32'hFFFF_FFFC;
    assign advance  = pc_write & if_id_write;

    // Memory-side outputs: a request is outstanding in every state except HELD.
    always_comb begin
        imem_req   = (state != HELD);
        imem_addr  = pc;
        fetch_busy = ((state == FETCH) && !imem_ready) || (state == DROP);
    end

    // Next-state, PC, hold buffer and IF/ID update; flush outranks any stall.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        redirect_pc_n = redirect_pc;
        hold_instr_n  = hold_instr;
        hold_pc4_n    = hold_pc4;
        id_instr_n    = if_id_instruction;
        id_pc4_n      = if_id_pc4;
        id_valid_n    = if_id_valid;

        if (if_flush) begin
            id_instr_n   = NOP_WORD;
            id_valid_n   = 1'b0;
            hold_instr_n = 32'd0;
            hold_pc4_n   = 32'd0;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc_n    = target;
                        state_n = FETCH;
                    end else begin
                        redirect_pc_n = target;
                        state_n       = DROP;
                    end
                end
                HELD: begin
                    pc_n    = target;
                    state_n = FETCH;
                end
                DROP: begin
                    redirect_pc_n = target;
                    if (imem_ready) begin
                        pc_n    = target;
                        state_n = FETCH;
                    end
                end
                default: begin
                    pc_n    = target;
                    state_n = FETCH;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (advance) begin
                            id_instr_n = imem_rdata;
                            id_pc4_n   = pc_plus4;
                            id_valid_n = 1'b1;
                            pc_n       = pc_plus4;
                        end else begin
                            hold_instr_n = imem_rdata;
                            hold_pc4_n   = pc_plus4;
                            state_n      = HELD;
                        end
                    end else if (if_id_write) begin
                        id_instr_n = NOP_WORD;
                        id_valid_n = 1'b0;
                    end
                end
                HELD: begin
                    if (advance) begin
                        id_instr_n = hold_instr;
                        id_pc4_n   = hold_pc4;
                        id_valid_n = 1'b1;
                        pc_n       = pc_plus4;
                        state_n    = FETCH;
                    end
                end
                DROP: begin
                    if (if_id_write) begin
                        id_instr_n = NOP_WORD;
                        id_valid_n = 1'b0;
                    end
                    if (imem_ready) begin
                        pc_n    = redirect_pc;
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // State, PC, hold buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            redirect_pc       <= 32'd0;
            hold_instr        <= 32'd0;
            hold_pc4          <= 32'd0;
            if_id_instruction <= NOP_WORD;
            if_id_pc4         <= 32'd0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            redirect_pc       <= redirect_pc_n;
            hold_instr        <= hold_instr_n;
            hold_pc4          <= hold_pc4_n;
            if_id_instruction <= id_instr_n;
            if_id_pc4         <= id_pc4_n;
            if_id_valid       <= id_valid_n;
        end
    end

`ifdef IF_STALL_COUNT_EN
    // Saturating count of cycles where decode is frozen or fetch is waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if ((!if_id_write || fetch_busy) && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
